// File: rtl/ram_bist.sv
// rtl/ram_bist.sv - four-phase pattern BIST initiator for the single-port ram
module ram_bist #(
    parameter int          DEPTH = 128,
    parameter logic [7:0]  SEED  = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       cs,
    output logic       we,
    output logic       oe,
    output logic [7:0] address,
    output logic [7:0] data_in,
    input  logic [7:0] data_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       fail_valid,
    output logic [7:0] fail_addr,
    output logic [7:0] err_count
);

    typedef enum logic [2:0] {ST_IDLE, ST_WR0, ST_RD0, ST_WR1, ST_RD1, ST_DONE} state_t;

    localparam logic [8:0] LAST  = 9'(DEPTH - 1);
    localparam logic [8:0] DRAIN = 9'(DEPTH);

    state_t     state, state_next;
    logic [8:0] cnt, cnt_next;
    logic       issue;
    logic [7:0] pattern;
    logic       cmp_valid;
    logic [7:0] cmp_addr;
    logic [7:0] cmp_exp;
    logic       start_accept;
    logic       hit;
    logic [7:0] err_next;

    assign start_accept = start && (state == ST_IDLE || state == ST_DONE);
    assign hit          = cmp_valid && (data_out != cmp_exp);
    assign err_next     = (hit && err_count != 8'hFF) ? err_count + 8'd1 : err_count;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cs         = 1'b0;
        we         = 1'b0;
        oe         = 1'b0;
        address    = 8'h00;
        data_in    = 8'h00;
        busy       = 1'b0;
        issue      = 1'b0;
        // Inverse pattern in the second write/read pair
        pattern    = (state == ST_WR1 || state == ST_RD1) ? ~(cnt[7:0] ^ SEED)
                                                          : (cnt[7:0] ^ SEED);
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_WR0;
                    cnt_next   = 9'd0;
                end
            end
            ST_WR0, ST_WR1: begin
                busy    = 1'b1;
                cs      = 1'b1;
                we      = 1'b1;
                address = cnt[7:0];
                data_in = pattern;
                if (cnt == LAST) begin
                    cnt_next   = 9'd0;
                    state_next = (state == ST_WR0) ? ST_RD0 : ST_RD1;
                end else begin
                    cnt_next = cnt + 9'd1;
                end
            end
            ST_RD0, ST_RD1: begin
                busy = 1'b1;
                if (cnt == DRAIN) begin
                    cnt_next   = 9'd0;
                    state_next = (state == ST_RD0) ? ST_WR1 : ST_DONE;
                end else begin
                    cs       = 1'b1;
                    oe       = 1'b1;
                    address  = cnt[7:0];
                    issue    = 1'b1;
                    cnt_next = cnt + 9'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= 9'd0;
            cmp_valid  <= 1'b0;
            cmp_addr   <= 8'h00;
            cmp_exp    <= 8'h00;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_valid <= 1'b0;
            fail_addr  <= 8'h00;
            err_count  <= 8'h00;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            // Read data arrives one cycle after issue; carry its context along
            cmp_valid <= issue;
            cmp_addr  <= address;
            cmp_exp   <= pattern;
            if (start_accept) begin
                done       <= 1'b0;
                pass       <= 1'b0;
                fail_valid <= 1'b0;
                fail_addr  <= 8'h00;
                err_count  <= 8'h00;
            end else begin
                err_count <= err_next;
                if (hit && !fail_valid) begin
                    fail_valid <= 1'b1;
                    fail_addr  <= cmp_addr;
                end
                if (state == ST_RD1 && cnt == DRAIN) begin
                    done <= 1'b1;
                    pass <= (err_next == 8'h00);
                end
            end
        end
    end

endmodule
